// File: rtl/sha256_block_sequencer.sv
// Sequences the SHA-256 round core over the blocks of a pre-padded message,
// carrying the chaining value between blocks and presenting the final digest.
module sha256_block_sequencer #(
    parameter logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
    parameter int           TIMEOUT = 80,
    parameter int           CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    input  logic             blk_first,
    input  logic             blk_last,
    output logic             core_load,
    output logic [511:0]     core_block,
    output logic [255:0]     core_h,
    input  logic             core_ready,
    input  logic [255:0]     core_hash,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [255:0]     dig_data,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] blk_count
);

    // state  | meaning
    // IDLE   | waiting for a block
    // LOAD   | core_load pulse, core inputs stable
    // RUN    | waiting for core_ready, timeout counting
    // UPDATE | core_hash becomes the new chaining value
    // OUT    | digest offered until dig_ready
    // ERR    | core timed out, left only by reset
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_UPDATE,
        ST_OUT,
        ST_ERR
    } state_t;

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state;
    logic [255:0]     chain;
    logic             in_msg;
    logic             last;
    logic [TMO_W-1:0] tmo_cnt;

    assign core_h    = chain;
    // Gated by reset so the block is never offered while held in reset.
    assign blk_ready = reset && (state == ST_IDLE);
    assign busy      = (state == ST_LOAD) || (state == ST_RUN) ||
                       (state == ST_UPDATE) || (state == ST_OUT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            chain      <= IV;
            in_msg     <= 1'b0;
            last       <= 1'b0;
            blk_count  <= '0;
            tmo_cnt    <= '0;
            core_load  <= 1'b0;
            core_block <= '0;
            dig_valid  <= 1'b0;
            dig_data   <= '0;
            error      <= 1'b0;
        end else begin
            core_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        core_block <= blk_data;
                        last       <= blk_last;
                        // A first block mid-message abandons the old message.
                        if (blk_first || !in_msg) begin
                            chain     <= IV;
                            blk_count <= '0;
                        end
                        in_msg    <= 1'b1;
                        core_load <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tmo_cnt <= '0;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_ready) begin
                        state <= ST_UPDATE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_cnt == TMO_LAST) begin
                            error <= 1'b1;
                            state <= ST_ERR;
                        end
                    end
                end
                ST_UPDATE: begin
                    chain     <= core_hash;
                    blk_count <= blk_count + 1'b1;
                    if (last) begin
                        dig_data  <= core_hash;
                        dig_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
                        in_msg    <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    error <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: a behavioural SHA-256 compression core
// drives the core side, and a scoreboard checks each delivered digest.
module tb_sha256_block_sequencer;

    localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_448 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_448A = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_448B = {480'h0, 32'h000001c0};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [255:0] dig;
        logic [15:0]  cnt;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         core_load;
    logic [511:0] core_block;
    logic [255:0] core_h;
    logic         core_ready;
    logic [255:0] core_hash;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] dig_data;
    logic         busy;
    logic         error;
    logic [15:0]  blk_count;

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         sb_q[$];
    logic [255:0] load_h[$];
    int           load_cnt = 0;
    int           core_lat = 2;
    logic         core_hang = 1'b0;

    sha256_block_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_first  (blk_first),
        .blk_last   (blk_last),
        .core_load  (core_load),
        .core_block (core_block),
        .core_h     (core_h),
        .core_ready (core_ready),
        .core_hash  (core_hash),
        .dig_valid  (dig_valid),
        .dig_ready  (dig_ready),
        .dig_data   (dig_data),
        .busy       (busy),
        .error      (error),
        .blk_count  (blk_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7]  + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, hh} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96]  + e, hin[95:64]    + f, hin[63:32]    + g, hin[31:0]     + hh};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Behavioural round core: captures h/block on core_load, answers core_lat cycles later.
    initial begin
        int cnt;
        logic [255:0] cap_h;
        logic [511:0] cap_b;
        cnt = 0;
        cap_h = '0;
        cap_b = '0;
        core_ready = 1'b0;
        core_hash = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0;
                core_ready = 1'b0;
            end else if (core_load) begin
                cap_h = core_h;
                cap_b = core_block;
                load_h.push_back(core_h);
                load_cnt++;
                core_ready = 1'b0;
                cnt = core_lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !core_hang) begin
                    core_hash = sha_compress(cap_h, cap_b);
                    core_ready = 1'b1;
                end
            end
        end
    end

    // Digest monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (dig_valid && dig_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_digest: got %h expected none", dig_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("digest", dig_data, e.dig);
                    chk("blk_count", 256'(blk_count), 256'(e.cnt));
                end
            end
        end
    end

    task automatic send_block(input logic [511:0] d, input logic f, input logic l);
        int i;
        i = 0;
        while (!blk_ready && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (!blk_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL blk_ready_wait: got 0 expected 1");
        end else begin
            blk_valid = 1'b1;
            blk_data  = d;
            blk_first = f;
            blk_last  = l;
            @(negedge clk);
            blk_valid = 1'b0;
            blk_first = 1'b0;
            blk_last  = 1'b0;
            for (int k = 0; k < 16; k++) blk_data[32*k +: 32] = $urandom();
        end
    endtask

    task automatic expect_digest(input logic [255:0] dig, input logic [15:0] cnt);
        exp_t e;
        e.dig = dig;
        e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drain", 256'(sb_q.size()), 256'(0));
    endtask

    initial begin
        reset = 1'b0;
        blk_valid = 1'b0;
        blk_data = '0;
        blk_first = 1'b0;
        blk_last = 1'b0;
        dig_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk1("rst_blk_ready", blk_ready, 1'b0);
        chk1("rst_core_load", core_load, 1'b0);
        chk("rst_core_block", core_block[255:0], 256'h0);
        chk("rst_core_h", core_h, IV);
        chk1("rst_dig_valid", dig_valid, 1'b0);
        chk("rst_dig_data", dig_data, 256'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk("rst_blk_count", 256'(blk_count), 256'(0));
        reset = 1'b1;
        @(negedge clk);
        chk1("idle_blk_ready", blk_ready, 1'b1);

        // Single "abc" block with latency check (core ready 2 cycles after load)
        core_lat = 2;
        load_h.delete();
        load_cnt = 0;
        expect_digest(DIG_ABC, 16'd1);
        send_block(BLK_ABC, 1'b1, 1'b1);
        chk1("abc_core_load", core_load, 1'b1);
        chk("abc_core_h", core_h, IV);
        chk("abc_core_block", core_block[511:256], BLK_ABC[511:256]);
        repeat (3) @(negedge clk);
        chk1("abc_dig_valid_early", dig_valid, 1'b0);
        @(negedge clk);
        chk1("abc_dig_valid_on_time", dig_valid, 1'b1);
        wait_done();
        chk("abc_load_pulses", 256'(load_cnt), 256'(1));

        // Two-block message
        core_lat = 3;
        load_h.delete();
        expect_digest(DIG_448, 16'd2);
        send_block(BLK_448A, 1'b1, 1'b0);
        send_block(BLK_448B, 1'b0, 1'b1);
        wait_done();
        chk("two_load_count", 256'(load_h.size()), 256'(2));
        if (load_h.size() >= 2) begin
            chk("two_h_blk1", load_h[0], IV);
            chk("two_h_blk2", load_h[1], sha_compress(IV, BLK_448A));
        end

        // Digest backpressure
        dig_ready = 1'b0;
        expect_digest(DIG_ABC, 16'd1);
        send_block(BLK_ABC, 1'b1, 1'b1);
        for (int i = 0; i < 200 && !dig_valid; i++) @(negedge clk);
        chk1("bp_dig_valid_rise", dig_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("bp_dig_valid_hold", dig_valid, 1'b1);
            chk("bp_dig_data_hold", dig_data, DIG_ABC);
            chk1("bp_blk_ready_low", blk_ready, 1'b0);
        end
        dig_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_blk_ready", blk_ready, 1'b1);
        chk1("bp_release_dig_valid", dig_valid, 1'b0);
        chk1("bp_release_busy", busy, 1'b0);
        wait_done();

        // blk_first mid-message restarts from IV
        core_lat = 2;
        load_h.delete();
        expect_digest(DIG_ABC, 16'd1);
        send_block(BLK_448A, 1'b1, 1'b0);
        send_block(BLK_ABC, 1'b1, 1'b1);
        wait_done();
        chk("restart_load_count", 256'(load_h.size()), 256'(2));
        if (load_h.size() >= 2) chk("restart_h_iv", load_h[1], IV);

        // Timeout: core never answers
        core_hang = 1'b1;
        send_block(BLK_ABC, 1'b1, 1'b1);
        repeat (80) @(negedge clk);
        chk1("tmo_error_not_yet", error, 1'b0);
        chk1("tmo_busy_in_run", busy, 1'b1);
        @(negedge clk);
        chk1("tmo_error_set", error, 1'b1);
        chk1("tmo_busy_err", busy, 1'b0);
        chk1("tmo_blk_ready", blk_ready, 1'b0);
        repeat (5) @(negedge clk);
        chk1("tmo_error_sticky", error, 1'b1);
        chk1("tmo_blk_ready_stays", blk_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk1("tmo_rst_error", error, 1'b0);
        chk1("tmo_rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        core_hang = 1'b0;
        @(negedge clk);
        chk1("tmo_idle_blk_ready", blk_ready, 1'b1);

        // Reset in the middle of RUN
        core_hang = 1'b1;
        send_block(BLK_ABC, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk1("midrst_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_dig_valid", dig_valid, 1'b0);
        chk("midrst_core_h", core_h, IV);
        @(negedge clk);
        reset = 1'b1;
        core_hang = 1'b0;
        core_lat = 2;
        @(negedge clk);
        expect_digest(DIG_ABC, 16'd1);
        send_block(BLK_ABC, 1'b0, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
